vtj1_irqctl: RTL and testbench



---
 rtl/vtj1_irqctl_pkg.sv | 26 ++
 rtl/irq_edge_sync.sv | 33 +++
 rtl/prienc32.sv | 22 ++
 rtl/vtj1_irqctl.sv | 129 ++++++++++++
 tb/tb_vtj1_irqctl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vtj1_irqctl_pkg.sv
// vtj1_irqctl_pkg: shared constants for the VTJ-1 interrupt controller.
//   Register addresses (byte addresses inside the I/O slot), the "no vector"
//   marker returned by VEC, and the CUR value shown when nothing is in service.
package vtj1_irqctl_pkg;

  localparam int NUM_SRC = 32;

  localparam logic [7:0] ADR_ENA  = 8'h00;  // 4 bytes, RW
  localparam logic [7:0] ADR_EDGE = 8'h10;  // 4 bytes, RW, 1 = edge mode
  localparam logic [7:0] ADR_RAW  = 8'h40;  // 4 bytes, RO synced lines
  localparam logic [7:0] ADR_PEND = 8'h50;  // 4 bytes, read pending / W1C
  localparam logic [7:0] ADR_ISR  = 8'h60;  // 4 bytes, RO in-service
  localparam logic [7:0] ADR_ACK  = 8'h80;
  localparam logic [7:0] ADR_VEC  = 8'h81;
  localparam logic [7:0] ADR_EOI  = 8'h82;
  localparam logic [7:0] ADR_CUR  = 8'h83;

  localparam logic [7:0] VEC_NONE = 8'hFF;
  localparam logic [5:0] CUR_IDLE = 6'd32;

  // Place a byte into lane `sel` of a 32-bit word, other lanes zero.
  function automatic logic [31:0] byte_lane(input logic [1:0] sel, input logic [7:0] d);
    return {24'b0, d} << {sel, 3'b000};
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// irq_edge_sync: one IRQ line through a SYNC_STAGES-deep synchroniser plus a
// delayed copy for rising-edge detection.
//   clk, rst   clock, async active-high reset
//   i_d        raw asynchronous line
//   o_s        synchronised level
//   o_rise     synchronised level rose this cycle (s & ~s_prev)
module irq_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_s,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_s    = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/prienc32.sv
// prienc32: 32-bit priority encoder, lowest set index wins.
//   i_vec  request vector
//   o_idx  index of lowest set bit, CUR_IDLE (32) when i_vec is zero
//   o_vld  any bit set
module prienc32
  import vtj1_irqctl_pkg::*;
(
  input  logic [31:0] i_vec,
  output logic [5:0]  o_idx,
  output logic        o_vld
);

  // Scan high to low so the last hit is the lowest index.
  always_comb begin
    o_idx = CUR_IDLE;
    for (int i = 31; i >= 0; i--)
      if (i_vec[i]) o_idx = 6'(i);
  end

  assign o_vld = |i_vec;

endmodule

// File: rtl/vtj1_irqctl.sv
// vtj1_irqctl: nesting, prioritising interrupt controller (one I/O slot).
//   clk, rst     clock, async active-high reset
//   adr, adr_d1  register address (adr_d1 unused, slot-interface uniformity)
//   wrt, wen     write data / enable
//   red          registered read data (wrt echoed on write cycles)
//   irqa, irqb   slot IRQs, tied low
//   irq_in[31:0] source lines, lower index = higher priority
//   irq          registered interrupt request to the CPU
module vtj1_irqctl
  import vtj1_irqctl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  adr,
  input  logic [7:0]  adr_d1,
  output logic [7:0]  red,
  input  logic [7:0]  wrt,
  input  logic        wen,
  output logic        irqa,
  output logic        irqb,
  input  logic [31:0] irq_in,
  output logic        irq
);

  logic [31:0] r_ena, r_edge, r_pend, r_isr;
  logic [7:0]  r_vec;
  logic        r_irq;

  logic [31:0] w_s, w_rise, w_eff, w_elig;
  logic [5:0]  w_best, w_cur;
  logic        w_best_vld, w_cur_vld;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_sync
    irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .i_d    (irq_in[gi]),
      .o_s    (w_s[gi]),
      .o_rise (w_rise[gi])
    );
  end

  // Level sources are pending exactly while their synced line is high.
  assign w_eff  = (r_pend & r_edge) | (w_s & ~r_edge);
  assign w_elig = w_eff & r_ena;

  prienc32 u_best (.i_vec(w_elig), .o_idx(w_best), .o_vld(w_best_vld));
  prienc32 u_cur  (.i_vec(r_isr),  .o_idx(w_cur),  .o_vld(w_cur_vld));

  // Register decode
  logic [7:0]  w_wsel;
  logic [31:0] w_wmask, w_bmask, w_ena_n, w_edge_n, w_pend_n, w_ack_oh, w_eoi_oh, w_pend_clr;
  logic        w_wr_ena, w_wr_edge, w_wr_pend, w_ack, w_eoi, w_ack_go;

  assign w_wsel    = {adr[7:2], 2'b00};
  assign w_wr_ena  = wen && (w_wsel == ADR_ENA);
  assign w_wr_edge = wen && (w_wsel == ADR_EDGE);
  assign w_wr_pend = wen && (w_wsel == ADR_PEND);
  assign w_ack     = wen && (adr == ADR_ACK);
  assign w_eoi     = wen && (adr == ADR_EOI);
  assign w_wmask   = byte_lane(adr[1:0], wrt);
  assign w_bmask   = byte_lane(adr[1:0], 8'hFF);

  assign w_ena_n  = w_wr_ena  ? ((r_ena  & ~w_bmask) | w_wmask) : r_ena;
  assign w_edge_n = w_wr_edge ? ((r_edge & ~w_bmask) | w_wmask) : r_edge;

  // ACK acts on the registered irq; best is re-checked so a level line that
  // dropped since irq was registered yields "no vector" instead of index 32.
  assign w_ack_go = w_ack && r_irq && w_best_vld;
  assign w_ack_oh = w_ack_go ? (32'd1 << w_best[4:0]) : '0;
  // Lowest set bit of ISR = the level currently being serviced.
  assign w_eoi_oh = w_eoi ? (r_isr & (~r_isr + 32'd1)) : '0;

  // New edges win over W1C/ACK clears; a mode change drops stale pending.
  assign w_pend_clr = (w_wr_pend ? w_wmask : '0) | w_ack_oh;
  assign w_pend_n   = ((r_pend & ~w_pend_clr) | (w_rise & r_edge)) & ~(w_edge_n ^ r_edge);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ena  <= '0;
      r_edge <= '0;
      r_pend <= '0;
      r_isr  <= '0;
      r_vec  <= VEC_NONE;
      r_irq  <= 1'b0;
    end else begin
      r_ena  <= w_ena_n;
      r_edge <= w_edge_n;
      r_pend <= w_pend_n;
      r_isr  <= (r_isr | w_ack_oh) & ~w_eoi_oh;
      if (w_ack) r_vec <= w_ack_go ? {3'b000, w_best[4:0]} : VEC_NONE;
      r_irq  <= w_best_vld && (w_best < w_cur);
    end
  end

  // Read path
  logic [31:0] w_word;
  logic [7:0]  w_rd;

  always_comb begin
    w_word = '0;
    case (w_wsel)
      ADR_ENA:  w_word = r_ena;
      ADR_EDGE: w_word = r_edge;
      ADR_RAW:  w_word = w_s;
      ADR_PEND: w_word = w_eff;
      ADR_ISR:  w_word = r_isr;
      default:  w_word = '0;
    endcase
    w_rd = w_word[{adr[1:0], 3'b000} +: 8];
    if (adr == ADR_VEC)      w_rd = r_vec;
    else if (adr == ADR_CUR) w_rd = {2'b00, w_cur};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) red <= '0;
    else     red <= wen ? wrt : w_rd;
  end

  assign irq  = r_irq;
  assign irqa = 1'b0;
  assign irqb = 1'b0;

  logic w_unused;
  assign w_unused = ^{adr_d1, w_cur_vld};

endmodule

// File: tb/tb_vtj1_irqctl.sv
// tb_vtj1_irqctl: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the controller.
module tb_vtj1_irqctl;

  localparam int SS = 2;

  logic        clk, rst;
  logic [7:0]  adr, adr_d1, red, wrt;
  logic        wen, irqa, irqb, irq;
  logic [31:0] irq_in;

  int checks = 0;
  int errors = 0;

  vtj1_irqctl #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .adr(adr), .adr_d1(adr_d1), .red(red),
    .wrt(wrt), .wen(wen), .irqa(irqa), .irqb(irqb),
    .irq_in(irq_in), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] hist [0:SS];   // hist[0] = irq_in sampled at the latest edge
  logic [31:0] m_ena, m_edge, m_pend, m_isr;
  logic [7:0]  m_vec, m_red;
  logic        m_irq;

  function automatic int lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 32;
  endfunction

  function automatic logic [7:0] rdmap(input logic [7:0] a, input logic [31:0] s,
                                       input logic [31:0] eff, input int cur);
    logic [31:0] w;
    logic [7:0]  r;
    w = '0;
    case (a & 8'hFC)
      8'h00: w = m_ena;
      8'h10: w = m_edge;
      8'h40: w = s;
      8'h50: w = eff;
      8'h60: w = m_isr;
      default: w = '0;
    endcase
    r = w[8*a[1:0] +: 8];
    if (a == 8'h81) r = m_vec;
    if (a == 8'h83) r = 8'(cur);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j <= SS; j++) hist[j] = '0;
      m_ena = '0; m_edge = '0; m_pend = '0; m_isr = '0;
      m_vec = 8'hFF; m_red = '0; m_irq = 1'b0;
    end else begin : step
      logic [31:0] s, sp, eff, ena_n, edge_n, pend_n, isr_n;
      int best, cur, lane;
      s   = hist[SS-1];
      sp  = hist[SS];
      eff = (m_pend & m_edge) | (s & ~m_edge);
      best = lowest(eff & m_ena);
      cur  = lowest(m_isr);
      ena_n = m_ena; edge_n = m_edge; pend_n = m_pend; isr_n = m_isr;
      lane = 8 * int'(adr[1:0]);
      m_red = wen ? wrt : rdmap(adr, s, eff, cur);
      if (wen) begin
        if ((adr & 8'hFC) == 8'h00) ena_n[lane +: 8]  = wrt;
        if ((adr & 8'hFC) == 8'h10) edge_n[lane +: 8] = wrt;
        if ((adr & 8'hFC) == 8'h50)
          for (int k = 0; k < 8; k++) if (wrt[k]) pend_n[lane + k] = 1'b0;
        if (adr == 8'h80) begin
          if (m_irq && best < 32) begin
            m_vec = 8'(best);
            isr_n[best] = 1'b1;
            pend_n[best] = 1'b0;
          end else m_vec = 8'hFF;
        end
        if (adr == 8'h82 && cur < 32) isr_n[cur] = 1'b0;
      end
      for (int i = 0; i < 32; i++) begin
        if (edge_n[i] != m_edge[i]) pend_n[i] = 1'b0;
        else if (m_edge[i] && s[i] && !sp[i]) pend_n[i] = 1'b1;
      end
      m_irq  = (best < 32) && (best < cur);
      m_ena  = ena_n; m_edge = edge_n; m_pend = pend_n; m_isr = isr_n;
      for (int j = SS; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = irq_in;
    end
  end

  always @(negedge clk) begin
    chk("red", red, m_red);
    chk("irq", irq, m_irq);
    chk("irqa", irqa, 0);
    chk("irqb", irqb, 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    adr = a; wrt = d; wen = 1'b1;
    cyc();
    wen = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    adr = a; wen = 1'b0;
    cyc();
    d = red;
  endtask

  task automatic pulse(input int i);
    irq_in[i] = 1'b1;
    cyc();
    irq_in[i] = 1'b0;
  endtask

  logic [7:0] d;
  logic [7:0] wlist [0:16];
  logic [7:0] rlist [0:25];

  initial begin
    wlist = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
              8'h50, 8'h51, 8'h52, 8'h53, 8'h80, 8'h82, 8'h80, 8'h82, 8'h60};
    rlist = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
              8'h40, 8'h41, 8'h42, 8'h43, 8'h50, 8'h51, 8'h52, 8'h53,
              8'h60, 8'h61, 8'h62, 8'h63, 8'h81, 8'h83, 8'h80, 8'h82, 8'h20, 8'hFF};
    rst = 1'b1; adr = '0; adr_d1 = '0; wrt = '0; wen = 1'b0; irq_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_red", red, 8'h00);
    chk("reset_irq", irq, 0);
    rst = 1'b0;
    rd(8'h81, d); chk("reset_vec", d, 8'hFF);
    rd(8'h83, d); chk("reset_cur", d, 8'h20);

    // edge source 0: four-edge latency, ACK, EOI
    wr(8'h00, 8'h01);
    wr(8'h10, 8'h01);
    pulse(0);
    cyc(); cyc();
    chk("lat_early", irq, 0);
    cyc();
    chk("lat_k3", irq, 1);
    wr(8'h80, 8'h00);
    rd(8'h81, d); chk("ack0_vec", d, 8'h00);
    chk("ack0_irq_drop", irq, 0);
    rd(8'h60, d); chk("ack0_isr", d, 8'h01);
    wr(8'h82, 8'h00);
    rd(8'h60, d); chk("eoi0_isr", d, 8'h00);

    // level source 5
    wr(8'h00, 8'h20);
    irq_in[5] = 1'b1;
    repeat (4) cyc();
    chk("lvl5_irq", irq, 1);
    wr(8'h80, 8'h00);
    rd(8'h81, d); chk("lvl5_vec", d, 8'h05);
    chk("lvl5_irq_off", irq, 0);
    wr(8'h82, 8'h00);
    cyc();
    chk("lvl5_reassert", irq, 1);
    irq_in[5] = 1'b0;
    repeat (4) cyc();
    chk("lvl5_gone", irq, 0);

    // nesting: 20 then 3
    wr(8'h00, 8'h08); wr(8'h02, 8'h10);
    wr(8'h10, 8'h08); wr(8'h12, 8'h10);
    pulse(20);
    repeat (4) cyc();
    chk("n20_irq", irq, 1);
    wr(8'h80, 8'h00);
    rd(8'h81, d); chk("n20_vec", d, 8'h14);
    pulse(3);
    repeat (4) cyc();
    chk("n3_irq", irq, 1);
    wr(8'h80, 8'h00);
    rd(8'h81, d); chk("n3_vec", d, 8'h03);
    rd(8'h83, d); chk("n3_cur", d, 8'h03);
    wr(8'h82, 8'h00);
    rd(8'h83, d); chk("eoi_cur20", d, 8'h14);
    wr(8'h82, 8'h00);
    rd(8'h83, d); chk("eoi_idle", d, 8'h20);

    // lower priority blocked
    wr(8'h00, 8'h04); wr(8'h01, 8'h02); wr(8'h02, 8'h00);
    wr(8'h10, 8'h04); wr(8'h11, 8'h02); wr(8'h12, 8'h00);
    pulse(2);
    repeat (4) cyc();
    wr(8'h80, 8'h00);
    rd(8'h81, d); chk("blk_vec2", d, 8'h02);
    pulse(9);
    repeat (4) cyc();
    chk("blk_irq", irq, 0);
    rd(8'h51, d); chk("blk_pend9", d, 8'h02);
    wr(8'h82, 8'h00);
    cyc();
    chk("blk_release", irq, 1);
    wr(8'h80, 8'h00);
    rd(8'h81, d); chk("blk_vec9", d, 8'h09);
    wr(8'h82, 8'h00);

    // nothing eligible
    wr(8'h80, 8'h00);
    rd(8'h81, d); chk("none_vec", d, 8'hFF);
    rd(8'h60, d); chk("none_isr0", d, 8'h00);
    rd(8'h61, d); chk("none_isr1", d, 8'h00);
    wr(8'h82, 8'h00);
    rd(8'h83, d); chk("none_cur", d, 8'h20);

    // W1C vs same-cycle edge on source 4
    wr(8'h00, 8'h10); wr(8'h01, 8'h00);
    wr(8'h10, 8'h10); wr(8'h11, 8'h00);
    pulse(4);
    repeat (4) cyc();
    rd(8'h50, d); chk("w1c_pre", d, 8'h10);
    wr(8'h50, 8'h10);
    rd(8'h50, d); chk("w1c_clear", d, 8'h00);
    irq_in[4] = 1'b1; cyc();
    irq_in[4] = 1'b0; cyc();
    wr(8'h50, 8'h10);
    rd(8'h50, d); chk("w1c_setwins", d, 8'h10);

    // async reset mid-ISR
    repeat (3) cyc();
    wr(8'h80, 8'hA5);
    chk("prerst_irq", irq, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_irq", irq, 0);
    chk("async_red", red, 8'h00);
    #2 rst = 1'b0;
    cyc();
    rd(8'h60, d); chk("rst_isr", d, 8'h00);
    rd(8'h81, d); chk("rst_vec", d, 8'hFF);
    rd(8'h00, d); chk("rst_ena", d, 8'h00);

    // randomized traffic, checked every cycle by the model
    for (int it = 0; it < 4000; it++) begin
      if ($urandom_range(7, 0) == 0) irq_in[$urandom_range(31, 0)] ^= 1'b1;
      if ($urandom_range(9, 0) < 3) begin
        adr = wlist[$urandom_range(16, 0)];
        wrt = 8'($urandom);
        wen = 1'b1;
      end else begin
        adr = rlist[$urandom_range(25, 0)];
        wen = 1'b0;
      end
      adr_d1 = 8'($urandom);
      if (it == 2000) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
      cyc();
    end
    wen = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
